// File: rtl/mem_bus_pkg.sv
// Shared defaults and FSM state encoding for the memory burst master.
package mem_bus_pkg;

    localparam int unsigned BITS_DEF   = 16;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_skid_buf.sv
// Two-entry skid buffer with registered outputs.
// Ports: i_valid/o_ready/i_data upstream, o_valid/i_ready/o_data downstream.
// The output register is the first entry and the skid register is the second.
// o_ready depends only on the skid register, so there is no combinational
// ready path from downstream to upstream.
module mem_skid_buf #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;

    // Next-state: refill the output slot whenever it frees up, and otherwise park the input in the skid slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire      = i_valid & ~skid_valid_q;

        if (!out_valid_q || i_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = i_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign o_ready = ~skid_valid_q;
    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;

endmodule

// File: rtl/mem_master.sv
// Burst memory master: accepts read/write burst commands and drives a simple
// synchronous-write / combinational-read memory port.
// Ports: i_clk, i_rst; command channel (i_cmd_*, o_cmd_ready);
// write-data channel (i_wdata_valid, o_wdata_ready, i_wdata);
// read-data channel (o_rdata_valid, i_rdata_ready, o_rdata, o_rdata_last);
// memory port (o_mem_rw, o_mem_addr, o_mem_data, i_mem_data); o_busy.
module mem_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned BITS   = BITS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    input  logic [BITS-1:0]   i_wdata,
    output logic              o_rdata_valid,
    input  logic              i_rdata_ready,
    output logic [BITS-1:0]   o_rdata,
    output logic              o_rdata_last,
    output logic              o_mem_rw,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [BITS-1:0]   o_mem_data,
    input  logic [BITS-1:0]   i_mem_data,
    output logic              o_busy
);

    localparam int unsigned PW = BITS + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              beat;
    logic              last_beat;
    logic              buf_in_ready;
    logic [PW-1:0]     buf_out;

    assign last_beat = (cnt_q == LEN_W'(0));

    // Next-state: a beat advances the address and count; the final beat keeps the address and returns to IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        beat    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr;
                    cnt_d   = i_cmd_len;
                    state_d = i_cmd_write ? WR : RD;
                end
            end
            RD:      beat = buf_in_ready;
            WR:      beat = i_wdata_valid;
            default: state_d = IDLE;
        endcase

        if (beat) begin
            if (last_beat) begin
                state_d = IDLE;
            end else begin
                addr_d = ADDR_W'(addr_q + 1'b1);
                cnt_d  = LEN_W'(cnt_q - 1'b1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read beats are captured straight from the combinational memory output.
    mem_skid_buf #(
        .WIDTH(PW)
    ) u_rbuf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (state_q == RD),
        .o_ready (buf_in_ready),
        .i_data  ({last_beat, i_mem_data}),
        .o_valid (o_rdata_valid),
        .i_ready (i_rdata_ready),
        .o_data  (buf_out)
    );

    assign o_rdata       = buf_out[BITS-1:0];
    assign o_rdata_last  = buf_out[BITS];
    assign o_cmd_ready   = (state_q == IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_wdata_ready = (state_q == WR);
    assign o_mem_rw      = (state_q == WR) & i_wdata_valid;
    assign o_mem_data    = i_wdata;
    assign o_mem_addr    = addr_q;

endmodule
